// File: rtl/mem_copy_pkg.sv
// Shared types and widths for the memory-copy DMA engine.
package mem_copy_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 16;

  // Copy engine phases: idle, read one word, write it back, report completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_addr_ctr.sv
// Word index / committed-word counter and the base+index address adders.
module mem_copy_addr_ctr
  import mem_copy_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned LW = LEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [AW-1:0] src_base_i,
  input  logic [AW-1:0] dst_base_i,
  input  logic [LW-1:0] len_i,
  output logic [AW-1:0] src_addr_o,
  output logic [AW-1:0] dst_addr_o,
  output logic          last_o,
  output logic [LW-1:0] count_o
);

  logic [LW-1:0] idx_q;
  logic [LW-1:0] idx_d;
  logic [LW-1:0] idx_inc;

  assign idx_inc = idx_q + LW'(1);

  // Index clears on an accepted start and advances once per committed write.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_inc;
    end
  end

  // Index register; doubles as the committed-word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Address sums wrap naturally at the address width.
  assign src_addr_o = src_base_i + AW'(idx_q);
  assign dst_addr_o = dst_base_i + AW'(idx_q);
  assign last_o     = (idx_inc == len_i);
  assign count_o    = idx_q;

endmodule

// File: rtl/mem_copy_dma.sv
// Block-copy bus initiator for the data memory: reads LEN words from
// src_base and writes them to dst_base, one word every two cycles.
// Optional feature: define MEM_COPY_CHECKSUM_EN to add a running sum
// of the copied words on the checksum output.
module mem_copy_dma
  import mem_copy_pkg::*;
#(
  parameter int unsigned addressSize = ADDR_W,
  parameter int unsigned dataSize    = DATA_W,
  parameter int unsigned lenSize     = LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [addressSize-1:0] src_base,
  input  logic [addressSize-1:0] dst_base,
  input  logic [lenSize-1:0]     len,
  input  logic [dataSize-1:0]    readData,
  output logic [addressSize-1:0] address,
  output logic [dataSize-1:0]    writeData,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [dataSize-1:0]    checksum,
`endif
  output logic [lenSize-1:0]     count
);

  state_e                 state_q;
  state_e                 state_d;
  logic [addressSize-1:0] src_q;
  logic [addressSize-1:0] dst_q;
  logic [lenSize-1:0]     len_q;
  logic [dataSize-1:0]    data_q;
  logic                   aborted_q;
  logic                   aborted_d;

  logic                   op_cap;
  logic                   data_ld;
  logic                   ctr_inc;
  logic                   ctr_last;
  logic [addressSize-1:0] src_addr;
  logic [addressSize-1:0] dst_addr;
  logic [lenSize-1:0]     ctr_count;

  mem_copy_addr_ctr #(
    .AW(addressSize),
    .LW(lenSize)
  ) u_addr_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (op_cap),
    .inc_i     (ctr_inc),
    .src_base_i(src_q),
    .dst_base_i(dst_q),
    .len_i     (len_q),
    .src_addr_o(src_addr),
    .dst_addr_o(dst_addr),
    .last_o    (ctr_last),
    .count_o   (ctr_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; abort overrides every transition while busy.
  always_comb begin
    state_d   = state_q;
    op_cap    = 1'b0;
    data_ld   = 1'b0;
    ctr_inc   = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_cap  = 1'b1;
          state_d = (len == '0) ? FIN : RD;
        end
      end
      RD: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          data_ld = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        // The write commits on this edge even when aborting, so count it.
        ctr_inc = 1'b1;
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (ctr_last) begin
          state_d = FIN;
        end else begin
          state_d = RD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, word buffer and abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (op_cap) begin
        src_q <= src_base;
        dst_q <= dst_base;
        len_q <= len;
      end
      if (data_ld) begin
        data_q <= readData;
      end
      aborted_q <= aborted_d;
    end
  end

  // Bus and status outputs decoded from registered state and counters only.
  always_comb begin
    address   = '0;
    writeData = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    case (state_q)
      RD: begin
        MemRead = 1'b1;
        address = src_addr;
      end
      WR: begin
        MemWrite  = 1'b1;
        address   = dst_addr;
        writeData = data_q;
      end
      default: begin
        MemRead = 1'b0;
      end
    endcase
  end

  assign busy    = (state_q == RD) || (state_q == WR);
  assign done    = (state_q == FIN);
  assign aborted = aborted_q;
  assign count   = ctr_count;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [dataSize-1:0] csum_q;

  // Running sum of every committed word, restarted by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (op_cap) begin
      csum_q <= '0;
    end else if (ctr_inc) begin
      csum_q <= csum_q + data_q;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma with a combinational-read memory model.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] src_base;
  logic [15:0] dst_base;
  logic [15:0] len;
  logic [15:0] readData;
  logic [15:0] address;
  logic [15:0] writeData;
  logic        MemRead;
  logic        MemWrite;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] count;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  localparam logic [15:0] WA = 16'hA11A;
  localparam logic [15:0] WB = 16'hB22B;
  localparam logic [15:0] WC = 16'hC33C;
  localparam logic [15:0] WD = 16'hD44D;

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;

  logic [15:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [15:0] mem [0:65535];

  mem_copy_dma dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .readData (readData),
    .address  (address),
    .writeData(writeData),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum (checksum),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  assign readData = mem[address];

  // Memory model: preload, then commit writes on the edge ending a write cycle.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    mem[16'h0000] <= 16'h02BC;
    mem[16'h0100] <= WA;
    mem[16'h0101] <= WB;
    mem[16'h0102] <= WC;
    mem[16'h0103] <= WD;
    mem[16'hFFFE] <= 16'h1E1E;
    mem[16'hFFFF] <= 16'h1F1F;
    forever begin
      @(posedge clk);
      if (MemWrite) mem[address] <= writeData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus monitor: every strobe is matched against the expected transaction queues.
  always @(negedge clk) begin
    if (!rst && (MemRead || MemWrite)) begin
      n_strobe++;
      chk("rw_exclusive", 32'(MemRead & MemWrite), 32'd0);
      if (MemRead) begin
        if (rd_q.size() == 0) chk("rd_unexpected", {16'hDEAD, address}, 32'hFFFF_FFFF);
        else chk("rd_addr", 32'(address), 32'(rd_q.pop_front()));
      end
      if (MemWrite) begin
        if (wr_q.size() == 0) chk("wr_unexpected", {address, writeData}, 32'hFFFF_FFFF);
        else chk("wr_addr_data", {address, writeData}, wr_q.pop_front());
      end
    end
  end

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n_rd, input int n_wr);
    for (int i = 0; i < n_rd; i++) rd_q.push_back(s + 16'(i));
    for (int i = 0; i < n_wr; i++) wr_q.push_back({d + 16'(i), mem[s + 16'(i)]});
  endtask

  task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(posedge clk);
    #1;
    start = 1'b1; src_base = s; dst_base = d; len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; c0 is the number of cycles already elapsed since the start edge.
  task automatic wait_done(input int c0, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = c0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic drained(input string tag);
    chk({tag, "_rd_drain"}, 32'(rd_q.size()), 32'd0);
    chk({tag, "_wr_drain"}, 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    int n_done;
    int s0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", {address, writeData}, 32'd0);
    chk("reset_flags", {11'd0, MemRead, MemWrite, busy, done, aborted, count}, 32'd0);
    rst = 1'b0;

    // Single word from the reset-valued word 0.
    push_copy(16'h0000, 16'h0010, 1, 1);
    kick(16'h0000, 16'h0010, 16'd1);
    wait_done(0, cyc);
    chk("t2_done_cyc", 32'(cyc), 32'd3);
    chk("t2_count", 32'(count), 32'd1);
    @(negedge clk);
    chk("t2_done_pulse", 32'(done), 32'd0);
    chk("t2_mem", 32'(mem[16'h0010]), 32'h02BC);
    drained("t2");

    // Four-word copy.
    push_copy(16'h0100, 16'h0200, 4, 4);
    kick(16'h0100, 16'h0200, 16'd4);
    wait_done(0, cyc);
    chk("t1_done_cyc", 32'(cyc), 32'd9);
    chk("t1_count", 32'(count), 32'd4);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t1_checksum", 32'(checksum), 32'(16'(WA + WB + WC + WD)));
`endif
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_mem0", 32'(mem[16'h0200]), 32'(WA));
    chk("t1_mem3", 32'(mem[16'h0203]), 32'(WD));
    drained("t1");

    // Zero length: immediate done, no bus traffic, count cleared.
    s0 = n_strobe;
    kick(16'h0100, 16'h0300, 16'd0);
    wait_done(0, cyc);
    chk("t3_done_cyc", 32'(cyc), 32'd1);
    chk("t3_count", 32'(count), 32'd0);
    chk("t3_no_strobe", 32'(n_strobe - s0), 32'd0);

    // Source wraps through the top of the address space.
    push_copy(16'hFFFE, 16'h0300, 3, 3);
    kick(16'hFFFE, 16'h0300, 16'd3);
    wait_done(0, cyc);
    chk("t4_done_cyc", 32'(cyc), 32'd7);
    chk("t4_mem2", 32'(mem[16'h0302]), 32'h02BC);
    drained("t4");

    // Abort during the second read: only the first word lands.
    push_copy(16'h0100, 16'h0400, 2, 1);
    kick(16'h0100, 16'h0400, 16'd4);
    repeat (3) @(negedge clk);
    chk("t5_in_rd", 32'(MemRead), 32'd1);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_aborted", 32'(aborted), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_count", 32'(count), 32'd1);
    @(negedge clk);
    chk("t5_aborted_pulse", 32'(aborted), 32'd0);
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("t5_no_done", 32'(n_done), 32'd0);
    chk("t5_mem0", 32'(mem[16'h0400]), 32'(WA));
    chk("t5_mem1", 32'(mem[16'h0401]), 32'd0);
    drained("t5");

    // Reset during a write cycle clears everything at once.
    push_copy(16'h0100, 16'h0500, 1, 1);
    kick(16'h0100, 16'h0500, 16'd4);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_bus", {address, writeData}, 32'd0);
    chk("t6_rst_flags", {11'd0, MemRead, MemWrite, busy, done, aborted, count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_nowrite", 32'(mem[16'h0500]), 32'd0);
    drained("t6a");

    // A start raised while busy must not disturb the copy in flight.
    push_copy(16'h0100, 16'h0600, 2, 2);
    kick(16'h0100, 16'h0600, 16'd2);
    @(negedge clk);
    #1;
    start = 1'b1; src_base = 16'h0000; dst_base = 16'h0700; len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, cyc);
    chk("t6_done_cyc", 32'(cyc), 32'd5);
    chk("t6_count", 32'(count), 32'd2);
    @(negedge clk);
    chk("t6_mem1", 32'(mem[16'h0601]), 32'(WB));
    chk("t6_ignored", 32'(mem[16'h0700]), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_still_idle", 32'(busy), 32'd0);
    drained("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
